// File: rtl/sprite_drawer.sv
// -----------------------------------------------------------------------------
// sprite_drawer
//   Per-object sprite datapath sitting behind the game FSM. Holds the object's
//   top-left position, applies horizontal/vertical shift commands at the start
//   of a scan, and streams the WIDTH x HEIGHT rectangle one pixel per clock to
//   the VGA adapter, followed by a one-cycle `complete_o` pulse.
//
//   Optional feature macro: SPRITE_MASK_EN
//     defined   : plot_o is additionally gated by MASK[row*WIDTH+col]
//     undefined : MASK is ignored, full rectangle is plotted
//
// Ports
//   clock_i          system clock (rising edge)
//   reset_i          asynchronous active-high reset
//   select_i         this object's draw line from the FSM
//   write_en_i       FSM write enable, a scan starts only when high
//   load_i           position load strobe (qualified by select_i)
//   load_x_i/_y_i    position to load
//   shift_h_i/_v_i   apply horizontal / vertical shift at scan start
//   clear_i          1 = erase pass (colour 0, no shift)
//   shift_amount_i   two's-complement shift amount
//   vga_x_o/_y_o     pixel coordinate
//   colour_o         pixel colour
//   plot_o           pixel write strobe
//   complete_o       one-cycle end-of-scan pulse
//   pos_x_o/_y_o     current top-left position
// -----------------------------------------------------------------------------
module sprite_drawer #(
  parameter int                        WIDTH   = 16,
  parameter int                        HEIGHT  = 16,
  parameter logic [2:0]                COLOUR  = 3'b111,
  parameter int                        X_LIMIT = 160,
  parameter int                        X_WRAP  = 180,
  parameter int                        Y_MAX   = 120,
  parameter logic [WIDTH*HEIGHT-1:0]   MASK    = '1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       select_i,
  input  logic       write_en_i,
  input  logic       load_i,
  input  logic [7:0] load_x_i,
  input  logic [6:0] load_y_i,
  input  logic       shift_h_i,
  input  logic       shift_v_i,
  input  logic       clear_i,
  input  logic [6:0] shift_amount_i,
  output logic [7:0] vga_x_o,
  output logic [6:0] vga_y_o,
  output logic [2:0] colour_o,
  output logic       plot_o,
  output logic       complete_o,
  output logic [7:0] pos_x_o,
  output logic [6:0] pos_y_o
);

  localparam logic [3:0] COL_LAST = 4'(WIDTH - 1);
  localparam logic [3:0] ROW_LAST = 4'(HEIGHT - 1);
  localparam logic [8:0] X_LIM9   = 9'(X_LIMIT);
  localparam logic [7:0] X_WRAP8  = 8'(X_WRAP);
  localparam logic [8:0] Y_TOP    = 9'(Y_MAX - HEIGHT);
`ifdef SPRITE_MASK_EN
  localparam logic [255:0] MASK_PAD = 256'(MASK);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t     state_q;
  logic [7:0] pos_x_q;
  logic [6:0] pos_y_q;
  logic [3:0] col_q;
  logic [3:0] row_q;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       complete_q;

  logic [7:0] shift_x_d;
  logic [6:0] shift_y_d;
  logic [8:0] sum_y_d;
  logic [3:0] next_col_d;
  logic [3:0] next_row_d;
  logic       last_pix_d;
`ifdef SPRITE_MASK_EN
  logic [7:0] mask_idx_d;
`endif

  // Pixel is on screen when the 9-bit column sum stays below X_LIMIT.
  function automatic logic x_visible(input logic [7:0] px, input logic [3:0] c);
    logic [8:0] sx;
    sx = {1'b0, px} + {5'b00000, c};
    return (sx < X_LIM9);
  endfunction

  // Position the scan will start from: shifts applied only on a draw pass.
  always_comb begin
    shift_x_d = pos_x_q;
    shift_y_d = pos_y_q;
    // 9-bit signed sum so negative results and clamp overflow are both visible
    sum_y_d   = {2'b00, pos_y_q} + {{2{shift_amount_i[6]}}, shift_amount_i};
    if (!clear_i && shift_h_i) begin
      if (pos_x_q < {1'b0, shift_amount_i}) begin
        shift_x_d = X_WRAP8;
      end else begin
        shift_x_d = pos_x_q - {1'b0, shift_amount_i};
      end
    end else begin
      shift_x_d = pos_x_q;
    end
    if (!clear_i && shift_v_i) begin
      if (sum_y_d[8]) begin
        shift_y_d = 7'd0;
      end else if (sum_y_d > Y_TOP) begin
        shift_y_d = Y_TOP[6:0];
      end else begin
        shift_y_d = sum_y_d[6:0];
      end
    end else begin
      shift_y_d = pos_y_q;
    end
  end

  // Row-major scan counter advance.
  always_comb begin
    next_col_d = col_q;
    next_row_d = row_q;
    last_pix_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
    if (col_q == COL_LAST) begin
      next_col_d = 4'd0;
      next_row_d = row_q + 4'd1;
    end else begin
      next_col_d = col_q + 4'd1;
      next_row_d = row_q;
    end
`ifdef SPRITE_MASK_EN
    mask_idx_d = 8'((int'(next_row_d) * WIDTH) + int'(next_col_d));
`endif
  end

  // Control FSM with registered pixel outputs and position.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      pos_x_q    <= 8'd0;
      pos_y_q    <= 7'd0;
      col_q      <= 4'd0;
      row_q      <= 4'd0;
      vga_x_q    <= 8'd0;
      vga_y_q    <= 7'd0;
      colour_q   <= 3'd0;
      plot_q     <= 1'b0;
      complete_q <= 1'b0;
    end else if (select_i && load_i) begin
      // Load wins over everything, including an active scan
      state_q    <= S_IDLE;
      pos_x_q    <= load_x_i;
      pos_y_q    <= load_y_i;
      plot_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_GAP: begin
          complete_q <= 1'b0;
          if (select_i && write_en_i) begin
            // Entry edge: commit shifted position and emit pixel (0,0)
            state_q  <= S_SCAN;
            pos_x_q  <= shift_x_d;
            pos_y_q  <= shift_y_d;
            col_q    <= 4'd0;
            row_q    <= 4'd0;
            vga_x_q  <= shift_x_d;
            vga_y_q  <= shift_y_d;
            colour_q <= clear_i ? 3'd0 : COLOUR;
`ifdef SPRITE_MASK_EN
            plot_q   <= x_visible(shift_x_d, 4'd0) & MASK_PAD[0];
`else
            plot_q   <= x_visible(shift_x_d, 4'd0);
`endif
          end else begin
            plot_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (!select_i) begin
            state_q <= S_IDLE;
            plot_q  <= 1'b0;
          end else if (last_pix_d) begin
            state_q    <= S_DONE;
            plot_q     <= 1'b0;
            complete_q <= 1'b1;
          end else begin
            col_q   <= next_col_d;
            row_q   <= next_row_d;
            vga_x_q <= pos_x_q + {4'b0000, next_col_d};
            vga_y_q <= pos_y_q + {3'b000, next_row_d};
`ifdef SPRITE_MASK_EN
            plot_q  <= x_visible(pos_x_q, next_col_d) & MASK_PAD[mask_idx_d];
`else
            plot_q  <= x_visible(pos_x_q, next_col_d);
`endif
          end
        end
        S_DONE: begin
          state_q    <= S_GAP;
          plot_q     <= 1'b0;
          complete_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          plot_q     <= 1'b0;
          complete_q <= 1'b0;
        end
      endcase
    end
  end

  assign vga_x_o    = vga_x_q;
  assign vga_y_o    = vga_y_q;
  assign colour_o   = colour_q;
  assign plot_o     = plot_q;
  assign complete_o = complete_q;
  assign pos_x_o    = pos_x_q;
  assign pos_y_o    = pos_y_q;

endmodule

// File: tb/tb_sprite_drawer.sv
// -----------------------------------------------------------------------------
// tb_sprite_drawer
//   Three instances share the input bus and differ only in select:
//     0: default 16x16, 1: 16x4 (missile), 2: 16x16 checkerboard MASK.
// -----------------------------------------------------------------------------
module tb_sprite_drawer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel;
  logic       we, load, sh, sv, clr;
  logic [7:0] lx;
  logic [6:0] ly;
  logic [6:0] amt;

  logic [7:0] vx  [3];
  logic [6:0] vy  [3];
  logic [2:0] col [3];
  logic       plot[3];
  logic       cmp [3];
  logic [7:0] px  [3];
  logic [6:0] py  [3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sprite_drawer u_a (
    .clock_i(clk), .reset_i(rst), .select_i(sel[0]), .write_en_i(we),
    .load_i(load), .load_x_i(lx), .load_y_i(ly), .shift_h_i(sh), .shift_v_i(sv),
    .clear_i(clr), .shift_amount_i(amt), .vga_x_o(vx[0]), .vga_y_o(vy[0]),
    .colour_o(col[0]), .plot_o(plot[0]), .complete_o(cmp[0]),
    .pos_x_o(px[0]), .pos_y_o(py[0]));

  sprite_drawer #(.HEIGHT(4)) u_b (
    .clock_i(clk), .reset_i(rst), .select_i(sel[1]), .write_en_i(we),
    .load_i(load), .load_x_i(lx), .load_y_i(ly), .shift_h_i(sh), .shift_v_i(sv),
    .clear_i(clr), .shift_amount_i(amt), .vga_x_o(vx[1]), .vga_y_o(vy[1]),
    .colour_o(col[1]), .plot_o(plot[1]), .complete_o(cmp[1]),
    .pos_x_o(px[1]), .pos_y_o(py[1]));

  sprite_drawer #(.MASK({8{32'hAAAA5555}})) u_c (
    .clock_i(clk), .reset_i(rst), .select_i(sel[2]), .write_en_i(we),
    .load_i(load), .load_x_i(lx), .load_y_i(ly), .shift_h_i(sh), .shift_v_i(sv),
    .clear_i(clr), .shift_amount_i(amt), .vga_x_o(vx[2]), .vga_y_o(vy[2]),
    .colour_o(col[2]), .plot_o(plot[2]), .complete_o(cmp[2]),
    .pos_x_o(px[2]), .pos_y_o(py[2]));

  typedef struct {
    int         lx, ly;
    logic       sh, sv, clr;
    logic [6:0] amt;
    int         ex, ey, eplots;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Called at a negedge; returns at a negedge with the load applied.
  task automatic do_load(input int d, input int x, input int y);
    sel  = 3'(1 << d);
    load = 1'b1;
    lx   = 8'(x);
    ly   = 7'(y);
    @(negedge clk);
    load = 1'b0;
    sel  = 3'b000;
  endtask

  // Called at a negedge; returns at the negedge of cycle t0+1 (pixel 0).
  task automatic start_scan(input int d, input logic c, input logic h,
                            input logic v, input logic [6:0] a);
    sel = 3'(1 << d);
    we  = 1'b1;
    clr = c;
    sh  = h;
    sv  = v;
    amt = a;
    @(negedge clk);
    // Inputs change after entry to show that the sampled values are held
    sh  = 1'b0;
    sv  = 1'b0;
    clr = ~c;
    amt = 7'd0;
  endtask

  // Counts plots from the current negedge until complete is seen (cycle index).
  task automatic collect(input int d, input logic [2:0] ecol, output int nplot,
                         output int done_cyc, output int last_x, output int last_y,
                         output int bad_col);
    nplot = 0; done_cyc = -1; last_x = -1; last_y = -1; bad_col = 0;
    for (int c = 1; c <= 400; c++) begin
      if (cmp[d]) begin
        done_cyc = c;
        break;
      end
      if (plot[d]) begin
        nplot++;
        last_x = int'(vx[d]);
        last_y = int'(vy[d]);
        if (col[d] != ecol) bad_col++;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_scan();
    sel = 3'b000;
    we  = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int np, dc, lxv, lyv, bc, cnt;

    vecs[0] = '{20, 30, 1'b1, 1'b0, 1'b0, 7'd5,   15,  30, 256};
    vecs[1] = '{0,  0,  1'b0, 1'b1, 1'b0, 7'h7F,  0,   0,  256};
    vecs[2] = '{10, 104,1'b0, 1'b1, 1'b0, 7'd1,   10,  104,256};
    vecs[3] = '{10, 100,1'b0, 1'b1, 1'b0, 7'd3,   10,  103,256};
    vecs[4] = '{50, 40, 1'b1, 1'b1, 1'b0, 7'h7E,  180, 38, 0};
    vecs[5] = '{150,10, 1'b0, 1'b0, 1'b0, 7'd0,   150, 10, 160};
    vecs[6] = '{30, 20, 1'b1, 1'b1, 1'b1, 7'd4,   30,  20, 256};
    vecs[7] = '{5,  5,  1'b1, 1'b0, 1'b0, 7'h7F,  180, 5,  0};
    vecs[8] = '{200,10, 1'b1, 1'b0, 1'b0, 7'd10,  190, 10, 0};
    vecs[9] = '{250,0,  1'b0, 1'b0, 1'b0, 7'd0,   250, 0,  0};

    rst = 1'b1; sel = 3'b000; we = 1'b0; load = 1'b0; sh = 1'b0; sv = 1'b0;
    clr = 1'b0; lx = 8'd0; ly = 7'd0; amt = 7'd0;
    repeat (2) @(negedge clk);
    check("rst_pos_x", int'(px[0]), 0);
    check("rst_pos_y", int'(py[0]), 0);
    check("rst_vga_x", int'(vx[0]), 0);
    check("rst_vga_y", int'(vy[0]), 0);
    check("rst_colour", int'(col[0]), 0);
    check("rst_plot", int'(plot[0]), 0);
    check("rst_complete", int'(cmp[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Load
    do_load(0, 72, 52);
    check("load_pos_x", int'(px[0]), 72);
    check("load_pos_y", int'(py[0]), 52);
    check("load_no_plot", int'(plot[0]), 0);

    // Erase then draw with select held high
    start_scan(0, 1'b1, 1'b0, 1'b0, 7'd0);
    check("erase_first_x", int'(vx[0]), 72);
    check("erase_first_y", int'(vy[0]), 52);
    collect(0, 3'd0, np, dc, lxv, lyv, bc);
    check("erase_plots", np, 256);
    check("erase_done_cyc", dc, 257);
    check("erase_last_x", lxv, 87);
    check("erase_last_y", lyv, 67);
    check("erase_bad_colour", bc, 0);
    clr = 1'b0; sv = 1'b1; amt = 7'h7F;
    @(negedge clk);
    check("gap_plot", int'(plot[0]), 0);
    check("gap_complete", int'(cmp[0]), 0);
    @(negedge clk);
    sv = 1'b0; amt = 7'd0;
    check("draw_pos_y", int'(py[0]), 51);
    check("draw_first_x", int'(vx[0]), 72);
    check("draw_first_y", int'(vy[0]), 51);
    check("draw_colour", int'(col[0]), 7);
    check("draw_first_plot", int'(plot[0]), 1);
    collect(0, 3'd7, np, dc, lxv, lyv, bc);
    check("draw_plots", np, 256);
    check("draw_done_cyc", dc, 257);
    finish_scan();

    // Table-driven scans on the 16x16 instance
    for (int i = 0; i < 10; i++) begin
      do_load(0, vecs[i].lx, vecs[i].ly);
      start_scan(0, vecs[i].clr, vecs[i].sh, vecs[i].sv, vecs[i].amt);
      check($sformatf("v%0d_pos_x", i), int'(px[0]), vecs[i].ex);
      check($sformatf("v%0d_pos_y", i), int'(py[0]), vecs[i].ey);
      check($sformatf("v%0d_first_x", i), int'(vx[0]), vecs[i].ex);
      check($sformatf("v%0d_first_y", i), int'(vy[0]), vecs[i].ey);
      check($sformatf("v%0d_colour", i), int'(col[0]), vecs[i].clr ? 0 : 7);
      collect(0, vecs[i].clr ? 3'd0 : 3'd7, np, dc, lxv, lyv, bc);
      check($sformatf("v%0d_plots", i), np, vecs[i].eplots);
      check($sformatf("v%0d_done_cyc", i), dc, 257);
      check($sformatf("v%0d_bad_colour", i), bc, 0);
      finish_scan();
    end

    // 16x4: horizontal underflow wrap, then right-edge clipping
    do_load(1, 0, 10);
    start_scan(1, 1'b0, 1'b1, 1'b0, 7'd1);
    check("wrap_pos_x", int'(px[1]), 180);
    collect(1, 3'd7, np, dc, lxv, lyv, bc);
    check("wrap_plots", np, 0);
    check("wrap_done_cyc", dc, 65);
    finish_scan();
    do_load(1, 150, 10);
    start_scan(1, 1'b0, 1'b0, 1'b0, 7'd0);
    collect(1, 3'd7, np, dc, lxv, lyv, bc);
    check("clip_plots", np, 40);
    check("clip_last_x", lxv, 159);
    check("clip_last_y", lyv, 13);
    check("clip_done_cyc", dc, 65);
    finish_scan();

    // Checkerboard mask instance
    do_load(2, 0, 0);
    start_scan(2, 1'b0, 1'b0, 1'b0, 7'd0);
    collect(2, 3'd7, np, dc, lxv, lyv, bc);
`ifdef SPRITE_MASK_EN
    check("mask_plots", np, 128);
`else
    check("mask_plots", np, 256);
`endif
    check("mask_done_cyc", dc, 257);
    finish_scan();

    // Abort: drop select at pixel 37, shift already applied is kept
    do_load(0, 40, 30);
    start_scan(0, 1'b0, 1'b0, 1'b1, 7'd2);
    repeat (37) @(negedge clk);
    check("abort_pix37_plot", int'(plot[0]), 1);
    check("abort_pix37_x", int'(vx[0]), 45);
    sel = 3'b000;
    @(negedge clk);
    check("abort_plot", int'(plot[0]), 0);
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (cmp[0] || plot[0]) cnt++;
      @(negedge clk);
    end
    check("abort_no_activity", cnt, 0);
    check("abort_pos_x", int'(px[0]), 40);
    check("abort_pos_y", int'(py[0]), 32);
    we = 1'b0;

    // Asynchronous reset at pixel 37
    do_load(0, 40, 30);
    start_scan(0, 1'b0, 1'b0, 1'b0, 7'd0);
    repeat (37) @(negedge clk);
    check("rstmid_pix37_plot", int'(plot[0]), 1);
    rst = 1'b1;
    #1;
    check("rstmid_plot", int'(plot[0]), 0);
    check("rstmid_pos_x", int'(px[0]), 0);
    check("rstmid_pos_y", int'(py[0]), 0);
    check("rstmid_vga_x", int'(vx[0]), 0);
    sel = 3'b000; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cmp[0] || plot[0]) cnt++;
    end
    check("rstmid_idle_after", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
